// File: rtl/pc_sequencer.sv
// Program-counter / memory-port sequencer for the multicycle-memory MIPS core.
// Walks FETCH -> (MEM) -> FETCH, issues the PC enable and source select, and parks in HALT.
module pc_sequencer #(
  parameter int MEM_TIMEOUT = 64,
  parameter int COUNT_W     = 32
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               ihit,
  input  logic               dhit,
  input  logic               is_load,
  input  logic               is_store,
  input  logic               is_jr,
  input  logic               is_j,
  input  logic               is_branch,
  input  logic               branch_taken,
  input  logic               is_halt,
  output logic               pc_en,
  output logic [1:0]         pc_src,
  output logic               imemREN,
  output logic               dmemREN,
  output logic               dmemWEN,
  output logic               halt,
  output logic               mem_timeout,
  output logic [COUNT_W-1:0] instr_count
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_MEM   = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [1:0] SRC_JR  = 2'd0;
  localparam logic [1:0] SRC_J   = 2'd1;
  localparam logic [1:0] SRC_BR  = 2'd2;
  localparam logic [1:0] SRC_PC4 = 2'd3;

  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  logic [1:0]         state_q, state_d;
  logic               load_q, load_d;
  logic               store_q, store_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               halt_q, halt_d;
  logic               timeout_q, timeout_d;
  logic [COUNT_W-1:0] count_q, count_d;

  // Next-state logic and combinational (Mealy) port/PC controls.
  always_comb begin
    state_d   = state_q;
    load_d    = load_q;
    store_d   = store_q;
    wait_d    = wait_q;
    halt_d    = halt_q;
    timeout_d = timeout_q;
    pc_en     = 1'b0;
    pc_src    = SRC_PC4;
    imemREN   = 1'b0;
    dmemREN   = 1'b0;
    dmemWEN   = 1'b0;

    case (state_q)
      ST_FETCH: begin
        imemREN = 1'b1;
        if (ihit) begin
          if (is_halt) begin
            state_d = ST_HALT;
            halt_d  = 1'b1;
          end else if (is_load || is_store) begin
            // A simultaneous load+store decode is resolved as a load.
            state_d = ST_MEM;
            load_d  = is_load;
            store_d = is_store & ~is_load;
            wait_d  = '0;
          end else begin
            pc_en = 1'b1;
            if (is_jr) begin
              pc_src = SRC_JR;
            end else if (is_j) begin
              pc_src = SRC_J;
            end else if (is_branch && branch_taken) begin
              pc_src = SRC_BR;
            end else begin
              pc_src = SRC_PC4;
            end
          end
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_MEM: begin
        dmemREN = load_q;
        dmemWEN = store_q;
        if (dhit) begin
          pc_en   = 1'b1;
          state_d = ST_FETCH;
          load_d  = 1'b0;
          store_d = 1'b0;
        end else begin
          if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + WAIT_W'(1);
          end else begin
            wait_d = wait_q;
          end
          timeout_d = timeout_q | (wait_d == WAIT_MAX);
        end
      end

      ST_HALT: begin
        halt_d = 1'b1;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Retired-instruction counter saturates instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (pc_en && (count_q != {COUNT_W{1'b1}})) begin
      count_d = count_q + COUNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // State, latched access type, wait counter and sticky status registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= ST_FETCH;
      load_q    <= 1'b0;
      store_q   <= 1'b0;
      wait_q    <= '0;
      halt_q    <= 1'b0;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      load_q    <= load_d;
      store_q   <= store_d;
      wait_q    <= wait_d;
      halt_q    <= halt_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
    end
  end

  assign halt        = halt_q;
  assign mem_timeout = timeout_q;
  assign instr_count = count_q;

endmodule
